// File: rtl/sudoku_pkg.sv
// sudoku_pkg: shared types for the Sudoku group pruner slice.
// Holds the FSM state enum, group-type codes, digit mask and div/mod-3 LUTs.
package sudoku_pkg;

    typedef logic [9:1] digit_mask_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_PRUNE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] GROUP_ROW = 2'd0;
    localparam logic [1:0] GROUP_COL = 2'd1;
    localparam logic [1:0] GROUP_BOX = 2'd2;

    localparam digit_mask_t ALL_CANDIDATES = 9'h1FF;

    function automatic logic [3:0] div3(input logic [3:0] v);
        case (v)
            4'd0, 4'd1, 4'd2:    div3 = 4'd0;
            4'd3, 4'd4, 4'd5:    div3 = 4'd1;
            4'd6, 4'd7, 4'd8:    div3 = 4'd2;
            4'd9, 4'd10, 4'd11:  div3 = 4'd3;
            4'd12, 4'd13, 4'd14: div3 = 4'd4;
            default:             div3 = 4'd5;
        endcase
    endfunction

    function automatic logic [3:0] mod3(input logic [3:0] v);
        case (v)
            4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15: mod3 = 4'd0;
            4'd1, 4'd4, 4'd7, 4'd10, 4'd13:       mod3 = 4'd1;
            default:                              mod3 = 4'd2;
        endcase
    endfunction

    // 3*v as a shift-add, kept at 4 bits (inputs never exceed 2 here).
    function automatic logic [3:0] times3(input logic [3:0] v);
        times3 = {v[2:0], 1'b0} + v;
    endfunction

endpackage

// File: rtl/sudoku_group_coord.sv
// sudoku_group_coord: maps (group_type, group_index, k) to a grid cell.
// Ports: group_type/group_index/k in; row/col out (0..8). Purely combinational.
module sudoku_group_coord
    import sudoku_pkg::*;
(
    input  logic [1:0] group_type,
    input  logic [3:0] group_index,
    input  logic [3:0] k,
    output logic [3:0] row,
    output logic [3:0] col
);

    logic [3:0] box_row;
    logic [3:0] box_col;

    assign box_row = times3(div3(group_index)) + div3(k);
    assign box_col = times3(mod3(group_index)) + mod3(k);

    always_comb begin
        row = group_index;
        col = k;
        case (group_type)
            GROUP_COL: begin
                row = k;
                col = group_index;
            end
            GROUP_BOX: begin
                row = box_row;
                col = box_col;
            end
            // Reserved code 3 behaves as a row.
            GROUP_ROW, 2'd3: begin
                row = group_index;
                col = k;
            end
        endcase
    end

endmodule

// File: rtl/sudoku_group_pruner.sv
// sudoku_group_pruner: scans one row/column/box, then ANDs ~seen into each valid mask.
// Ports: clk, reset_n, start, group_type, group_index in; busy, done, conflict,
// changed, cell_row/cell_col/cell_address/cell_we/cell_wdata out; cell_rdata in.
module sudoku_group_pruner
    import sudoku_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] group_type,
    input  logic [3:0] group_index,
    output logic       busy,
    output logic       done,
    output logic       conflict,
    output logic       changed,
    output logic [3:0] cell_row,
    output logic [3:0] cell_col,
    output logic       cell_address,
    output logic       cell_we,
    output logic [8:0] cell_wdata,
    input  logic [8:0] cell_rdata
);

    state_t      state_q;
    state_t      state_nx;
    logic [1:0]  gtype_q;
    logic [1:0]  gtype_nx;
    logic [3:0]  gidx_q;
    logic [3:0]  gidx_nx;
    logic [3:0]  k_q;
    logic [3:0]  k_nx;
    digit_mask_t seen_q;
    digit_mask_t seen_nx;
    logic        conflict_nx;
    logic        changed_nx;
    logic [3:0]  row_nx;
    logic [3:0]  col_nx;
    logic        hit;

    assign hit = |(cell_rdata & seen_q);

    always_comb begin
        state_nx    = state_q;
        gtype_nx    = gtype_q;
        gidx_nx     = gidx_q;
        k_nx        = k_q;
        seen_nx     = seen_q;
        conflict_nx = conflict;
        changed_nx  = changed;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_nx    = ST_SCAN;
                    gtype_nx    = group_type;
                    gidx_nx     = (group_index > 4'd8) ? 4'd8 : group_index;
                    k_nx        = 4'd0;
                    seen_nx     = '0;
                    conflict_nx = 1'b0;
                    changed_nx  = 1'b0;
                end
            end
            ST_SCAN: begin
                seen_nx = seen_q | cell_rdata;
                if (hit) conflict_nx = 1'b1;
                if (k_q == 4'd8) begin
                    k_nx     = 4'd0;
                    state_nx = conflict_nx ? ST_DONE : ST_PRUNE;
                end else begin
                    k_nx = k_q + 4'd1;
                end
            end
            ST_PRUNE: begin
                // rdata is the pre-write mask, so any overlap means a bit drops.
                if (hit) changed_nx = 1'b1;
                if (k_q == 4'd8) state_nx = ST_DONE;
                else k_nx = k_q + 4'd1;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Address is computed from next-state values so it is registered
    // and valid in the very cycle the scan/prune step uses it.
    sudoku_group_coord u_coord (
        .group_type  (gtype_nx),
        .group_index (gidx_nx),
        .k           (k_nx),
        .row         (row_nx),
        .col         (col_nx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            gtype_q      <= GROUP_ROW;
            gidx_q       <= 4'd0;
            k_q          <= 4'd0;
            seen_q       <= '0;
            conflict     <= 1'b0;
            changed      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cell_we      <= 1'b0;
            cell_address <= 1'b0;
            cell_row     <= 4'd0;
            cell_col     <= 4'd0;
        end else begin
            state_q      <= state_nx;
            gtype_q      <= gtype_nx;
            gidx_q       <= gidx_nx;
            k_q          <= k_nx;
            seen_q       <= seen_nx;
            conflict     <= conflict_nx;
            changed      <= changed_nx;
            busy         <= (state_nx != ST_IDLE);
            done         <= (state_nx == ST_DONE);
            cell_we      <= (state_nx == ST_PRUNE);
            cell_address <= (state_nx == ST_PRUNE);
            cell_row     <= row_nx;
            cell_col     <= col_nx;
        end
    end

    // Gated by cell_we so the bus idles at zero outside PRUNE.
    assign cell_wdata = cell_we ? ~seen_q : '0;

endmodule

// File: tb/tb_sudoku_group_pruner.sv
// tb_sudoku_group_pruner: self-checking bench with a behavioural 9x9 grid model.
// Directed table, back-to-back/ignored-start and mid-PRUNE reset cases, random passes.
module tb_sudoku_group_pruner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [1:0] group_type;
    logic [3:0] group_index;
    logic       busy;
    logic       done;
    logic       conflict;
    logic       changed;
    logic [3:0] cell_row;
    logic [3:0] cell_col;
    logic       cell_address;
    logic       cell_we;
    logic [8:0] cell_wdata;
    logic [8:0] cell_rdata;

    always #5 clk = ~clk;

    sudoku_group_pruner dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .group_type   (group_type),
        .group_index  (group_index),
        .busy         (busy),
        .done         (done),
        .conflict     (conflict),
        .changed      (changed),
        .cell_row     (cell_row),
        .cell_col     (cell_col),
        .cell_address (cell_address),
        .cell_we      (cell_we),
        .cell_wdata   (cell_wdata),
        .cell_rdata   (cell_rdata)
    );

    // Grid: placed value and candidate mask per cell (bit d-1 = digit d).
    logic [8:0] val [9][9];
    logic [8:0] vm  [9][9];

    always_comb begin
        cell_rdata = '0;
        if (cell_row < 4'd9 && cell_col < 4'd9)
            cell_rdata = cell_address ? vm[cell_row][cell_col]
                                      : val[cell_row][cell_col];
    end

    // A solved cell forces its mask to zero on any write.
    always @(posedge clk) begin
        if (cell_we && cell_row < 4'd9 && cell_col < 4'd9)
            vm[cell_row][cell_col] <= (val[cell_row][cell_col] != 9'h0) ? 9'h0
                : (vm[cell_row][cell_col] & cell_wdata);
    end

    int done_cnt = 0;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model state.
    int         exp_r [9];
    int         exp_c [9];
    logic [8:0] exp_seen;
    bit         exp_conf;
    bit         exp_chg;
    logic [8:0] exp_vm [9][9];

    task automatic model(input logic [1:0] gt, input logic [3:0] gi);
        int g;
        int x;
        int n;
        int cnt [10];
        g = (gt == 2'd3) ? 0 : int'(gt);
        x = (gi > 4'd8) ? 8 : int'(gi);
        n = 0;
        if (g == 2) begin
            for (int dr = 0; dr < 3; dr++)
                for (int dc = 0; dc < 3; dc++) begin
                    exp_r[n] = 3 * (x / 3) + dr;
                    exp_c[n] = 3 * (x % 3) + dc;
                    n++;
                end
        end else begin
            for (int k = 0; k < 9; k++) begin
                exp_r[k] = (g == 0) ? x : k;
                exp_c[k] = (g == 0) ? k : x;
            end
        end
        for (int d = 0; d < 10; d++) cnt[d] = 0;
        exp_seen = '0;
        for (int k = 0; k < 9; k++) begin
            exp_seen |= val[exp_r[k]][exp_c[k]];
            for (int d = 1; d <= 9; d++)
                if (val[exp_r[k]][exp_c[k]][d-1]) cnt[d]++;
        end
        exp_conf = 1'b0;
        for (int d = 1; d <= 9; d++) if (cnt[d] > 1) exp_conf = 1'b1;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) exp_vm[r][c] = vm[r][c];
        exp_chg = 1'b0;
        if (!exp_conf) begin
            for (int k = 0; k < 9; k++) begin
                if ((vm[exp_r[k]][exp_c[k]] & exp_seen) != 9'h0) exp_chg = 1'b1;
                exp_vm[exp_r[k]][exp_c[k]] = (val[exp_r[k]][exp_c[k]] != 9'h0) ? 9'h0
                    : (vm[exp_r[k]][exp_c[k]] & ~exp_seen);
            end
        end
    endtask

    // Observations from one pass.
    int         sr [18];
    int         sc [18];
    int         sa [18];
    logic [8:0] wlog [$];
    bit         bad_we;
    bit         busy_bad;
    int         dcyc;
    logic       r_conf;
    logic       r_chg;

    task automatic run_pass(input logic [1:0] gt, input logic [3:0] gi,
                            input int poke, input int rst_at);
        @(negedge clk);
        group_type  = gt;
        group_index = gi;
        start       = 1'b1;
        dcyc = 0;
        bad_we = 1'b0;
        busy_bad = 1'b0;
        r_conf = 1'bx;
        r_chg = 1'bx;
        wlog.delete();
        for (int i = 0; i < 18; i++) begin
            sr[i] = -1;
            sc[i] = -1;
            sa[i] = -1;
        end
        for (int cyc = 1; cyc <= 40 && dcyc == 0; cyc++) begin
            @(negedge clk);
            start = (cyc == poke);
            // Group inputs must be latched; scramble them mid-pass.
            group_type  = 2'($urandom);
            group_index = 4'($urandom);
            if (cyc == rst_at) begin
                reset_n = 1'b0;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_we", cell_we, 0);
                chk("rst_done", done, 0);
                start = 1'b0;
                return;
            end
            if (cyc <= 18) begin
                sr[cyc-1] = cell_row;
                sc[cyc-1] = cell_col;
                sa[cyc-1] = cell_address;
            end
            if (cell_we) begin
                wlog.push_back(cell_wdata);
                if (cyc < 10 || cyc > 18) bad_we = 1'b1;
            end
            if (!busy) busy_bad = 1'b1;
            if (done) begin
                dcyc = cyc;
                r_conf = conflict;
                r_chg = changed;
            end
        end
        start = 1'b0;
    endtask

    task automatic verify(input string nm);
        int e;
        chk({nm, ".done_cyc"}, dcyc, exp_conf ? 10 : 19);
        chk({nm, ".conflict"}, r_conf, exp_conf);
        chk({nm, ".changed"}, r_chg, exp_chg);
        chk({nm, ".writes"}, wlog.size(), exp_conf ? 0 : 9);
        e = 0;
        for (int k = 0; k < 9; k++) begin
            if (sr[k] != exp_r[k] || sc[k] != exp_c[k] || sa[k] != 0) e++;
            if (!exp_conf && (sr[k+9] != exp_r[k] || sc[k+9] != exp_c[k] || sa[k+9] != 1)) e++;
        end
        chk({nm, ".coords"}, e, 0);
        e = 0;
        foreach (wlog[i]) if (wlog[i] !== ~exp_seen) e++;
        chk({nm, ".wdata"}, e, 0);
        chk({nm, ".we_window"}, bad_we, 0);
        chk({nm, ".busy"}, busy_bad, 0);
        e = 0;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                if (vm[r][c] !== exp_vm[r][c]) e++;
        chk({nm, ".masks"}, e, 0);
    endtask

    task automatic setup(input int id);
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) begin
                val[r][c] = 9'h0;
                vm[r][c] <= 9'h1FF;
            end
        case (id)
            0: for (int c = 0; c < 8; c++) begin
                val[2][c] = 9'(1 << c);
                vm[2][c] <= 9'h0;
            end
            1: begin
                val[1][5] = 9'h008;
                val[6][5] = 9'h008;
                vm[1][5] <= 9'h0;
                vm[6][5] <= 9'h0;
            end
            3: begin
                val[0][8] = 9'h010;
                vm[0][8] <= 9'h0;
            end
            default: ;
        endcase
        #1;
    endtask

    task automatic setup_rand(input int fill);
        logic [8:0] v;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) begin
                v = 9'h0;
                if ($urandom_range(0, 99) < fill) begin
                    if ($urandom_range(0, 9) == 0) v = 9'($urandom);
                    else v = 9'(1 << $urandom_range(0, 8));
                end
                val[r][c] = v;
                vm[r][c] <= (v != 9'h0) ? 9'h0 : 9'($urandom);
            end
        #1;
    endtask

    typedef struct {
        int         id;
        logic [1:0] gt;
        logic [3:0] gi;
        int         exp_done;
        bit         exp_conf;
        bit         exp_chg;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int e;
        int d0;
        tbl[0] = '{0, 2'd0, 4'd2,  19, 1'b0, 1'b1};
        tbl[1] = '{1, 2'd1, 4'd5,  10, 1'b1, 1'b0};
        tbl[2] = '{2, 2'd2, 4'd4,  19, 1'b0, 1'b0};
        tbl[3] = '{2, 2'd3, 4'd12, 19, 1'b0, 1'b0};

        reset_n = 1'b0;
        start = 1'b0;
        group_type = 2'd0;
        group_index = 4'd0;
        setup(2);
        #12;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.flags", {conflict, changed}, 0);
        chk("rst.bus", {cell_we, cell_address, cell_row, cell_col}, 0);
        chk("rst.wdata", cell_wdata, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            setup(tbl[i].id);
            model(tbl[i].gt, tbl[i].gi);
            run_pass(tbl[i].gt, tbl[i].gi, 0, 0);
            verify($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.done_tbl", i), dcyc, tbl[i].exp_done);
            chk($sformatf("vec%0d.conf_tbl", i), r_conf, tbl[i].exp_conf);
            chk($sformatf("vec%0d.chg_tbl", i), r_chg, tbl[i].exp_chg);
            if (i == 0) chk("vec0.cell28", vm[2][8], 9'h100);
        end

        // Start during a pass is ignored; start right after DONE is taken.
        setup(0);
        d0 = done_cnt;
        model(2'd0, 4'd2);
        run_pass(2'd0, 4'd2, 5, 0);
        verify("poke");
        model(2'd0, 4'd2);
        run_pass(2'd0, 4'd2, 0, 0);
        verify("b2b");
        chk("b2b.changed_again", r_chg, 0);
        repeat (4) @(negedge clk);
        chk("done_pulses", done_cnt - d0, 2);

        // Reset in PRUNE k=4: cells 0..3 pruned, 4..8 untouched.
        setup(3);
        run_pass(2'd0, 4'd0, 0, 14);
        @(negedge clk);
        reset_n = 1'b1;
        e = 0;
        for (int c = 0; c < 4; c++) if (vm[0][c] !== 9'h1EF) e++;
        for (int c = 4; c < 8; c++) if (vm[0][c] !== 9'h1FF) e++;
        if (vm[0][8] !== 9'h0) e++;
        chk("rst_mid.masks", e, 0);
        model(2'd0, 4'd0);
        run_pass(2'd0, 4'd0, 0, 0);
        verify("after_rst");
        chk("after_rst.changed", r_chg, 1);

        for (int it = 0; it < 24; it++) begin
            logic [1:0] gt;
            logic [3:0] gi;
            gt = 2'($urandom_range(0, 3));
            gi = 4'($urandom_range(0, 15));
            setup_rand((it % 3 == 0) ? 40 : 15);
            model(gt, gi);
            run_pass(gt, gi, 0, 0);
            verify($sformatf("rnd%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
